// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin grant among functional-unit
// completion ports into a single registered broadcast stage with
// back-pressure from the ROB and a pipeline flush.
module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int TAG_WIDTH  = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_FU-1:0]              fu_valid,
  input  logic [NUM_FU*TAG_WIDTH-1:0]    fu_tag,
  input  logic [NUM_FU*ADDR_WIDTH-1:0]   fu_dest,
  input  logic [NUM_FU*DATA_WIDTH-1:0]   fu_data,
  output logic [NUM_FU-1:0]              fu_ready,
  input  logic                           cdb_ready,
  input  logic                           flush,
  output logic                           cdb_valid,
  output logic [TAG_WIDTH-1:0]           cdb_tag,
  output logic [ADDR_WIDTH-1:0]          cdb_dest,
  output logic [DATA_WIDTH-1:0]          cdb_data,
  output logic                           cdb_wr_reg
);

  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  // One extra bit so ptr + offset never overflows before the wrap test.
  localparam logic [PTR_W:0]   NUM_FU_W = (PTR_W + 1)'(NUM_FU);
  localparam logic [PTR_W-1:0] LAST_FU  = PTR_W'(NUM_FU - 1);

  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                  cdb_valid_q, cdb_valid_d;
  logic [TAG_WIDTH-1:0]  cdb_tag_q, cdb_tag_d;
  logic [ADDR_WIDTH-1:0] cdb_dest_q, cdb_dest_d;
  logic [DATA_WIDTH-1:0] cdb_data_q, cdb_data_d;

  logic                  can_load_s;
  logic                  found_s;
  logic                  grant_s;
  logic [PTR_W-1:0]      grant_idx_s;
  logic [NUM_FU-1:0]     fu_ready_s;
  logic [TAG_WIDTH-1:0]  sel_tag_s;
  logic [ADDR_WIDTH-1:0] sel_dest_s;
  logic [DATA_WIDTH-1:0] sel_data_s;

  // The output stage can take a new beat when empty or being drained now.
  assign can_load_s = !cdb_valid_q || cdb_ready;

  // Round-robin search: first valid unit at or after rr_ptr, wrapping.
  always_comb begin : rr_search
    logic [PTR_W:0]   sum_v;
    logic [PTR_W-1:0] idx_v;
    found_s     = 1'b0;
    grant_idx_s = '0;
    sum_v       = '0;
    idx_v       = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      sum_v = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
      if (sum_v >= NUM_FU_W) begin
        sum_v = sum_v - NUM_FU_W;
      end else begin
        sum_v = sum_v;
      end
      idx_v = sum_v[PTR_W-1:0];
      if (!found_s && fu_valid[idx_v]) begin
        found_s     = 1'b1;
        grant_idx_s = idx_v;
      end else begin
        found_s     = found_s;
      end
    end
  end

  // Qualify the search result and form the one-hot grant vector.
  always_comb begin
    grant_s    = found_s && can_load_s && !flush && !rst;
    fu_ready_s = '0;
    if (grant_s) begin
      fu_ready_s[grant_idx_s] = 1'b1;
    end else begin
      fu_ready_s = '0;
    end
  end

  // Select the granted unit's tag, destination and result.
  always_comb begin
    sel_tag_s  = '0;
    sel_dest_s = '0;
    sel_data_s = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (grant_idx_s == PTR_W'(i)) begin
        sel_tag_s  = fu_tag[i*TAG_WIDTH +: TAG_WIDTH];
        sel_dest_s = fu_dest[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data_s = fu_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        sel_tag_s  = sel_tag_s;
      end
    end
  end

  // Next state of the output register and round-robin pointer.
  always_comb begin
    cdb_valid_d = cdb_valid_q;
    cdb_tag_d   = cdb_tag_q;
    cdb_dest_d  = cdb_dest_q;
    cdb_data_d  = cdb_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (flush) begin
      cdb_valid_d = 1'b0;
    end else if (grant_s) begin
      cdb_valid_d = 1'b1;
      cdb_tag_d   = sel_tag_s;
      cdb_dest_d  = sel_dest_s;
      cdb_data_d  = sel_data_s;
      if (grant_idx_s == LAST_FU) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx_s + PTR_W'(1);
      end
    end else if (cdb_valid_q && cdb_ready) begin
      cdb_valid_d = 1'b0;
    end else begin
      cdb_valid_d = cdb_valid_q;
    end
  end

  // State registers; reset discards any beat in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_dest_q  <= '0;
      cdb_data_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_dest_q  <= cdb_dest_d;
      cdb_data_q  <= cdb_data_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign fu_ready   = fu_ready_s;
  assign cdb_valid  = cdb_valid_q;
  assign cdb_tag    = cdb_tag_q;
  assign cdb_dest   = cdb_dest_q;
  assign cdb_data   = cdb_data_q;
  // Writes to r0 are suppressed at the register file.
  assign cdb_wr_reg = cdb_valid_q && (cdb_dest_q != '0);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a reference round-robin model
// predicts each grant and pushes the expected beat into a scoreboard
// queue whose head is compared against the CDB every cycle.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int TW = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct packed {
    logic [TW-1:0] tag;
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    fu_valid;
  logic [N*TW-1:0] fu_tag;
  logic [N*AW-1:0] fu_dest;
  logic [N*DW-1:0] fu_data;
  logic [N-1:0]    fu_ready;
  logic            cdb_ready;
  logic            flush;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [AW-1:0]   cdb_dest;
  logic [DW-1:0]   cdb_data;
  logic            cdb_wr_reg;

  logic [TW-1:0]   tag_a  [N];
  logic [AW-1:0]   dest_a [N];
  logic [DW-1:0]   data_a [N];

  beat_t exp_q[$];
  int    m_rr       = 0;
  int    last_grant = -1;
  int    cmp_cnt    = 0;
  int    err_cnt    = 0;
  logic [N-1:0] pend;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      fu_tag[i*TW +: TW]  = tag_a[i];
      fu_dest[i*AW +: AW] = dest_a[i];
      fu_data[i*DW +: DW] = data_a[i];
    end
  end

  cdb_arbiter #(.NUM_FU(N), .TAG_WIDTH(TW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_dest(fu_dest), .fu_data(fu_data),
    .fu_ready(fu_ready), .cdb_ready(cdb_ready), .flush(flush),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_dest(cdb_dest),
    .cdb_data(cdb_data), .cdb_wr_reg(cdb_wr_reg)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_unit(input int i, input logic [TW-1:0] t,
                          input logic [AW-1:0] d, input logic [DW-1:0] x);
    tag_a[i]  = t;
    dest_a[i] = d;
    data_a[i] = x;
  endtask

  // One clock: drive, predict and check grant, update model, check CDB.
  task automatic cycle(input logic [N-1:0] v, input logic rdy,
                       input logic fl, input logic r);
    logic [N-1:0] exp_rdy;
    logic         mvalid;
    int           g;
    int           idx;
    beat_t        b;
    @(negedge clk);
    fu_valid  = v;
    cdb_ready = rdy;
    flush     = fl;
    rst       = r;
    #1;
    mvalid  = (exp_q.size() != 0);
    g       = -1;
    exp_rdy = '0;
    if (!r && !fl && (!mvalid || rdy)) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("fu_ready", 64'(fu_ready), 64'(exp_rdy));
    if (r) begin
      exp_q.delete();
      m_rr = 0;
    end else if (fl) begin
      if (mvalid) void'(exp_q.pop_front());
    end else begin
      if (mvalid && rdy) void'(exp_q.pop_front());
      if (g >= 0) begin
        b.tag  = tag_a[g];
        b.dest = dest_a[g];
        b.data = data_a[g];
        exp_q.push_back(b);
        m_rr = (g + 1) % N;
      end
    end
    last_grant = g;
    @(posedge clk);
    #1;
    chk("cdb_valid", 64'(cdb_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      b = exp_q[0];
      chk("cdb_tag",    64'(cdb_tag),    64'(b.tag));
      chk("cdb_dest",   64'(cdb_dest),   64'(b.dest));
      chk("cdb_data",   64'(cdb_data),   64'(b.data));
      chk("cdb_wr_reg", 64'(cdb_wr_reg), 64'(b.dest != '0));
    end else begin
      chk("cdb_wr_reg_idle", 64'(cdb_wr_reg), 64'd0);
    end
  endtask

  task automatic chk_zero();
    chk("rst_fu_ready", 64'(fu_ready),   64'd0);
    chk("rst_valid",    64'(cdb_valid),  64'd0);
    chk("rst_tag",      64'(cdb_tag),    64'd0);
    chk("rst_dest",     64'(cdb_dest),   64'd0);
    chk("rst_data",     64'(cdb_data),   64'd0);
    chk("rst_wr_reg",   64'(cdb_wr_reg), 64'd0);
  endtask

  initial begin
    rst = 1'b1; fu_valid = '0; cdb_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < N; i++) set_unit(i, TW'(i + 1), AW'(i + 10), DW'(32'h1000 + i));

    // Reset state.
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    chk_zero();

    // Single request from unit 0.
    set_unit(0, 4'd5, 5'd3, 32'hDEAD);
    cycle(4'b0001, 1'b1, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);

    // All units requesting from reset: grants 0,1,2,3,0,1 at full rate.
    cycle(4'b0000, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) set_unit(i, TW'(i + 1), AW'(i + 10), DW'(32'hA000 + i));
    for (int c = 0; c < 6; c++) cycle(4'b1111, 1'b1, 1'b0, 1'b0);

    // Unit 2 granted, then back-pressure for 3 cycles, then 3 then 0.
    cycle(4'b0100, 1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) cycle(4'b1001, 1'b0, 1'b0, 1'b0);
    cycle(4'b1001, 1'b1, 1'b0, 1'b0);
    cycle(4'b0001, 1'b1, 1'b0, 1'b0);

    // Flush with a live beat and all units requesting.
    cycle(4'b1111, 1'b1, 1'b1, 1'b0);
    cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);

    // Write to r0 is broadcast but suppressed for the register file.
    set_unit(0, 4'd7, 5'd0, 32'h1234);
    cycle(4'b0001, 1'b1, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);

    // Reset with a beat in flight and requests pending.
    cycle(4'b1111, 1'b1, 1'b0, 1'b0);
    cycle(4'b1111, 1'b1, 1'b0, 1'b1);
    chk_zero();
    cycle(4'b1100, 1'b1, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0, 1'b0);

    // Random traffic; each unit holds its request and fields until granted.
    pend = '0;
    for (int it = 0; it < 60; it++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1'b1;
          set_unit(i, TW'($urandom), AW'($urandom_range(0, 31)), DW'($urandom));
        end
      end
      cycle(pend, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 1'b0);
      if (last_grant >= 0) pend[last_grant] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter for the common data bus (CDB), placed between the functional-unit completion ports and the ROB/producer-table broadcast port.
- Up to NUM_FU units present completed results each cycle. One is granted per cycle and registered onto the CDB.
- The CDB drives the producer table's ROB write-back inputs (enable, dest, tag), the ROB result write and the reservation-station wakeup.
- Supports back-pressure from the ROB and a pipeline flush.

Parameters:
- NUM_FU, 4, number of requesting functional units (2..8)
- TAG_WIDTH, 4, ROB tag width (matches `ROB_SIZE)
- ADDR_WIDTH, 5, architectural register address width (matches `REG_ADDR_WIDTH)
- DATA_WIDTH, 32, result width

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- fu_valid  in  NUM_FU  per-unit result-valid
- fu_tag  in  NUM_FU*TAG_WIDTH  ROB tag per unit; slice i = [i*TAG_WIDTH +: TAG_WIDTH]
- fu_dest  in  NUM_FU*ADDR_WIDTH  destination register per unit
- fu_data  in  NUM_FU*DATA_WIDTH  result per unit
- fu_ready  out  NUM_FU  one-hot grant; result accepted this cycle when fu_valid[i] && fu_ready[i]
- cdb_ready  in  1  ROB/consumer accepts current CDB beat
- flush  in  1  discard CDB contents and block grants this cycle
- cdb_valid  out  1  broadcast valid (drives producer-table rob_en)
- cdb_tag  out  TAG_WIDTH  broadcast ROB tag
- cdb_dest  out  ADDR_WIDTH  broadcast destination register
- cdb_data  out  DATA_WIDTH  broadcast result
- cdb_wr_reg  out  1  cdb_valid && cdb_dest != 0 (r0 writes suppressed)

Behaviour:
- Reset: cdb_valid=0, cdb_tag/dest/data=0, cdb_wr_reg=0, rr_ptr=0, fu_ready=0. rst wins over every other input; a beat in flight at reset is lost without an error.
- Output stage is a single register. can_load = !cdb_valid || cdb_ready.
- Grant is combinational from fu_valid, rr_ptr and can_load:
  - Search starts at index rr_ptr and wraps modulo NUM_FU.
  - The first i with fu_valid[i] gets fu_ready[i]=1; all other bits are 0.
  - fu_ready is all zero when can_load=0, flush=1, rst=1 or no valid requests.
- fu_ready never asserts without the matching fu_valid. At most one bit is set.
- Latency: granted in cycle N, so cdb_valid=1 with that unit's tag/dest/data in cycle N+1.
- Output register update, first matching rule wins:
  - flush: cdb_valid<=0.
  - grant: load the granted unit's fields and set cdb_valid<=1.
  - cdb_valid && cdb_ready: cdb_valid<=0.
  - otherwise: hold.
- While cdb_valid=1 and cdb_ready=0, cdb_tag/dest/data stay stable.
- Back-to-back: a grant is allowed in the same cycle cdb_ready consumes the current beat. Full throughput is one result per cycle.
- rr_ptr: on grant to unit g, rr_ptr <= (g+1) mod NUM_FU; otherwise it holds. flush does not change rr_ptr.
- Fairness: a unit holding fu_valid continuously waits at most NUM_FU-1 grants before its own.
- Units must hold fu_valid and their fields stable until granted. The arbiter does not buffer ungranted results.
- Non-power-of-two NUM_FU wrap is correct, e.g. NUM_FU=3: 2 -> 0.
- cdb_wr_reg is combinational from the output register.

Test Plan:
- Reset, then fu_valid=0001, tag=5, dest=3, data=0xDEAD, cdb_ready=1 -> fu_ready=0001 in the same cycle; next cycle cdb_valid=1, tag=5, dest=3, data=0xDEAD, cdb_wr_reg=1.
- All four units valid every cycle, cdb_ready=1 -> grant order 0,1,2,3,0,1; cdb_valid stays high continuously; rr_ptr wraps 3 -> 0.
- Unit 2 granted, then cdb_ready=0 for 3 cycles with units 0 and 3 valid -> fu_ready=0000 and CDB holds unit 2's fields for 3 cycles; when cdb_ready=1, unit 3 is granted (rr_ptr=3) and then unit 0.
- cdb_valid=1 and flush=1 with fu_valid=1111 -> fu_ready=0000; next cycle cdb_valid=0 and rr_ptr is unchanged; with flush=0 the following cycle, the grant resumes at rr_ptr.
- fu_valid=0001 with dest=0, tag=7 -> cdb_valid=1, cdb_tag=7, cdb_wr_reg=0.
- rst asserted while cdb_valid=1 and units are requesting -> next cycle all outputs are 0 and rr_ptr=0; after rst deasserts, fu_valid=1100 grants unit 2 first.
